dcs_requant: RTL and testbench

Downstream stage of the DCS transformer datapath. Consumes each burst of eight 32-bit head-output words from the attention/weight multiply stage and buffers it in a two-bank ping-pong store. Computes a per-burst power-of-two scale from the burst maximum, then streams the requantised 8-bit values to the next consumer over a valid/ready handshake.

---
 rtl/dcs_requant.sv | 174 +++++++++++++++++
 tb/tb_dcs_requant.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcs_requant.sv
// dcs_requant: ping-pong burst buffer with per-burst power-of-two requantisation.
// Define DCS_REQUANT_ROUND_EN for round-half-up; default build truncates.
module dcs_requant #(
    parameter int N_WORDS = 8,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SH_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [SH_W-1:0]  out_shift,
    output logic             out_last,
    output logic             err
);

    localparam int AW = $clog2(N_WORDS);
    localparam logic [AW-1:0] LAST = AW'(N_WORDS - 1);

    localparam logic [2:0] S_EMPTY = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_READY = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]      r_st     [2];
    logic [2:0]      w_st_nxt [2];
    logic [IN_W-1:0] r_mem    [2][N_WORDS];
    logic [IN_W-1:0] r_max    [2];
    logic [SH_W-1:0] r_shift  [2];
    logic            r_wp;
    logic            r_rp;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   r_ridx;
    logic            r_drop;
    logic            r_err;

    logic            w_rd_act;
    logic            w_xfer;
    logic            w_rd_end;
    logic [2:0]      w_wst;
    logic            w_start;
    logic            w_fill;
    logic            w_beat;
    logic            w_wr_end;
    logic            w_ovf;
    logic            w_short;
    logic [IN_W-1:0] w_word;
    logic [SH_W-1:0] w_sh;
    logic [IN_W:0]   w_q;
    logic [OUT_W-1:0] w_sat;

    function automatic logic [SH_W-1:0] f_shift(input logic [IN_W-1:0] v);
        logic [SH_W-1:0] msb;
        msb = '0;
        for (int i = 0; i < IN_W; i++)
            if (v[i]) msb = SH_W'(i);
        if (msb >= SH_W'(OUT_W))
            return msb - SH_W'(OUT_W - 1);
        return '0;
    endfunction

    assign w_rd_act = (r_st[r_rp] == S_READY) || (r_st[r_rp] == S_DRAIN);
    assign w_xfer   = w_rd_act && out_ready;
    assign w_rd_end = w_xfer && (r_ridx == LAST);
    assign w_wst    = r_st[r_wp];
    assign w_fill   = !r_drop && (w_wst == S_FILL);
    assign w_start  = in_valid && !r_drop && (w_wst == S_EMPTY);
    assign w_beat   = in_valid && (w_start || w_fill);
    assign w_wr_end = in_valid && w_fill && (r_cnt == LAST);
    assign w_ovf    = in_valid && !r_drop && !w_start && !w_fill;
    assign w_short  = !in_valid && w_fill;

    // Write and read sides only ever touch disjoint bank states.
    always_comb begin
        w_st_nxt[0] = r_st[0];
        w_st_nxt[1] = r_st[1];
        for (int b = 0; b < 2; b++)
            if (r_st[b] == S_CALC) w_st_nxt[b] = S_READY;
        if (w_rd_act) w_st_nxt[r_rp] = w_rd_end ? S_EMPTY : S_DRAIN;
        if (w_start)  w_st_nxt[r_wp] = S_FILL;
        if (w_wr_end) w_st_nxt[r_wp] = S_CALC;
        if (w_short)  w_st_nxt[r_wp] = S_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st[0] <= S_EMPTY;
            r_st[1] <= S_EMPTY;
        end else begin
            r_st[0] <= w_st_nxt[0];
            r_st[1] <= w_st_nxt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat) r_mem[r_wp][r_cnt] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_cnt   <= '0;
            r_ridx  <= '0;
            r_drop  <= 1'b0;
            r_err   <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                r_max[b]   <= '0;
                r_shift[b] <= '0;
            end
        end else begin
            if (w_beat) begin
                if (w_start || (in_data > r_max[r_wp]))
                    r_max[r_wp] <= in_data;
                r_cnt <= w_wr_end ? '0 : r_cnt + AW'(1);
            end
            // The pointer moves with the last beat so a back-to-back burst lands in the other bank.
            if (w_wr_end) r_wp <= ~r_wp;
            if (w_ovf) begin
                r_drop <= 1'b1;
                r_err  <= 1'b1;
                r_cnt  <= AW'(1);
            end
            if (r_drop) begin
                if (!in_valid || (r_cnt == LAST)) begin
                    r_drop <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + AW'(1);
                end
            end
            if (w_short) begin
                r_err <= 1'b1;
                r_cnt <= '0;
            end
            if (w_xfer) begin
                r_ridx <= w_rd_end ? '0 : r_ridx + AW'(1);
                if (w_rd_end) r_rp <= ~r_rp;
            end
            for (int b = 0; b < 2; b++)
                if (r_st[b] == S_CALC) r_shift[b] <= f_shift(r_max[b]);
        end
    end

    assign w_word = r_mem[r_rp][r_ridx];
    assign w_sh   = r_shift[r_rp];

`ifdef DCS_REQUANT_ROUND_EN
    localparam logic [IN_W:0] ONE = 1;
    logic [IN_W:0] w_half;
    logic [IN_W:0] w_sum;
    assign w_half = (w_sh != '0) ? (ONE << (w_sh - SH_W'(1))) : '0;
    assign w_sum  = {1'b0, w_word} + w_half;
    assign w_q    = w_sum >> w_sh;
`else
    assign w_q = {1'b0, w_word} >> w_sh;
`endif

    assign w_sat = (|w_q[IN_W:OUT_W]) ? '1 : w_q[OUT_W-1:0];

    always_comb begin
        out_valid = w_rd_act;
        out_data  = w_rd_act ? w_sat : '0;
        out_shift = w_rd_act ? w_sh : '0;
        out_last  = w_rd_act && (r_ridx == LAST);
        err       = r_err;
    end

endmodule

// File: tb/tb_dcs_requant.sv
// Scoreboard bench for dcs_requant: directed bursts, expected beats queued at issue.
// Follows DCS_REQUANT_ROUND_EN to pick rounded or truncated expectations.
module tb_dcs_requant;

    typedef logic [31:0] burst_t [8];
    typedef logic [7:0]  obyte_t [8];
    typedef struct packed {
        logic [7:0] d;
        logic [4:0] s;
        logic       l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [4:0]  out_shift;
    logic        out_last;
    logic        err;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    dcs_requant dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: got data=%0d shift=%0d last=%0d, required no beat",
                         out_data, out_shift, out_last);
            end else begin
                e = q.pop_front();
                if (out_data !== e.d || out_shift !== e.s || out_last !== e.l) begin
                    n_err++;
                    $display("FAIL beat: got data=%0d shift=%0d last=%0d, required data=%0d shift=%0d last=%0d",
                             out_data, out_shift, out_last, e.d, e.s, e.l);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, expv);
        end
    endtask

    task automatic send(input burst_t w, input int nb);
        for (int i = 0; i < nb; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic push(input obyte_t d, input logic [4:0] s);
        for (int i = 0; i < 8; i++)
            q.push_back('{d: d[i], s: s, l: (i == 7)});
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_done", q.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    burst_t w_id  = '{0, 1, 2, 3, 4, 5, 6, 7};
    burst_t w_sc  = '{32'h1000, 48, 0, 0, 0, 0, 0, 0};
    burst_t w_sat = '{32'h1FF0, 32'h100, 15, 16, 32'h1FE0, 0, 0, 0};
    burst_t w_z   = '{0, 0, 0, 0, 0, 0, 0, 0};
    burst_t w_a   = '{100, 101, 102, 103, 104, 105, 106, 107};
    burst_t w_b   = '{32'h200, 32'h1FF, 3, 2, 6, 32'h100, 1, 0};
    burst_t w_c   = '{9, 9, 9, 9, 9, 9, 9, 9};
    burst_t w_d   = '{10, 11, 12, 13, 14, 15, 16, 17};
    burst_t w_e   = '{32'hFFFFFFFF, 32'h80000000, 1, 32'h00800000,
                      32'h007FFFFF, 32'h12345678, 32'h01000000, 0};

`ifdef DCS_REQUANT_ROUND_EN
    obyte_t e_sc  = '{128, 2, 0, 0, 0, 0, 0, 0};
    obyte_t e_sat = '{255, 8, 0, 1, 255, 0, 0, 0};
    obyte_t e_b   = '{128, 128, 1, 1, 2, 64, 0, 0};
    obyte_t e_e   = '{255, 128, 0, 1, 0, 18, 1, 0};
`else
    obyte_t e_sc  = '{128, 1, 0, 0, 0, 0, 0, 0};
    obyte_t e_sat = '{255, 8, 0, 0, 255, 0, 0, 0};
    obyte_t e_b   = '{128, 127, 0, 0, 1, 64, 0, 0};
    obyte_t e_e   = '{255, 128, 0, 0, 0, 18, 1, 0};
`endif
    obyte_t e_id  = '{0, 1, 2, 3, 4, 5, 6, 7};
    obyte_t e_z   = '{0, 0, 0, 0, 0, 0, 0, 0};
    obyte_t e_a   = '{100, 101, 102, 103, 104, 105, 106, 107};
    obyte_t e_d   = '{10, 11, 12, 13, 14, 15, 16, 17};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_shift", out_shift, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err", err, 0);

        // identity burst with latency check
        push(e_id, 0);
        send(w_id, 8);
        @(negedge clk);
        chk("lat_calc_cycle_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_first_valid", out_valid, 1);
        @(posedge clk);
        #1;
        wait_drain(40);

        push(e_sc, 5);
        send(w_sc, 8);
        wait_drain(40);
        chk("scaled_err", err, 0);

        push(e_sat, 5);
        send(w_sat, 8);
        wait_drain(40);

        push(e_z, 0);
        send(w_z, 8);
        wait_drain(40);

        // backpressure: A and B buffered, C dropped
        out_ready = 1'b0;
        push(e_a, 0);
        push(e_b, 2);
        send(w_a, 8);
        send(w_b, 8);
        chk("ovf_err_before_c", err, 0);
        send(w_c, 8);
        chk("ovf_err", err, 1);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, 100);
        idle(3);
        chk("stall_data_held", out_data, 100);
        chk("stall_last_held", out_last, 0);
        out_ready = 1'b1;
        wait_drain(60);
        idle(3);
        chk("ovf_no_c", out_valid, 0);

        // short burst
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("short_err_pre", err, 0);
        send(w_z, 3);
        chk("short_err_before_fall", err, 0);
        idle(1);
        chk("short_err", err, 1);
        idle(4);
        chk("short_no_output", out_valid, 0);

        // reset mid-drain
        push(e_d, 0);
        send(w_d, 8);
        for (int i = 0; i < 40 && q.size() > 5; i++) begin
            @(posedge clk);
        end
        #1;
        chk("mid_drain_progress", q.size(), 5);
        out_ready = 1'b0;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        push(e_e, 24);
        send(w_e, 8);
        wait_drain(40);
        idle(3);
        chk("final_idle", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
